// File: rtl/pipelined_write_rx_pkg.sv
// Shared types for the pipelined-write link receiver: link cycle layouts,
// write/cycle type encodings, rx state encoding and beat-count helpers.
package pipelined_write_rx_pkg;

  localparam int LINK_W   = 10;
  localparam int LINK_DAT = 8;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_DATA  = 2'd1,
    RX_DRAIN = 2'd2
  } rx_state_e;

  typedef logic [2:0] beat_cnt_t;

  // num_cycles==0 on the link means a full-length write
  localparam beat_cnt_t NUM0_BEATS = 3'd4;

  typedef enum logic [2:0] {
    WT_STD          = 3'd0,
    WT_MULTI_WDONE  = 3'd1,
    WT_SINGLE_WDONE = 3'd2
  } WRITE_TYPE__ET;

  typedef enum logic [1:0] {
    CT_IDLE  = 2'd0,
    CT_VALID = 2'd1,
    CT_DONE  = 2'd2,
    CT_RSVD  = 2'd3
  } CYCLE_TYPE__ET;

  typedef struct packed {
    logic [3:0] rsvd;
    logic       val;
    logic [1:0] num_cycles;
    logic [2:0] write_type;
  } write_cmd__st;

  typedef struct packed {
    logic [1:0]          cycle_type;
    logic [LINK_DAT-1:0] dat;
  } write_dat__st;

  function automatic beat_cnt_t num_to_beats(input logic [1:0] n);
    return (n == 2'd0) ? NUM0_BEATS : beat_cnt_t'({1'b0, n});
  endfunction

endpackage

// File: rtl/pipelined_write_rx_slot.sv
// Output holding register for assembled writes: valid/ready handshake,
// load-while-handshake passthrough and overflow detection on a busy slot.
module pipelined_write_rx_slot
  import pipelined_write_rx_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [DW-1:0] i_dat,
  input  beat_cnt_t     i_beats,
  input  logic [2:0]    i_type,
  input  logic          i_rdy,
  output logic          o_vld,
  output logic [DW-1:0] o_dat,
  output beat_cnt_t     o_beats,
  output logic [2:0]    o_type,
  output logic          o_ovf
);

  logic          r_vld, r_ovf;
  logic [DW-1:0] r_dat;
  beat_cnt_t     r_beats;
  logic [2:0]    r_type;
  logic          w_free;

  // A handshake in the same cycle frees the slot for the incoming write
  assign w_free = !r_vld || i_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld   <= 1'b0;
      r_ovf   <= 1'b0;
      r_dat   <= '0;
      r_beats <= '0;
      r_type  <= '0;
    end else begin
      r_ovf <= i_load && !w_free;
      if (i_load && w_free) begin
        r_vld   <= 1'b1;
        r_dat   <= i_dat;
        r_beats <= i_beats;
        r_type  <= i_type;
      end else if (r_vld && i_rdy) begin
        r_vld <= 1'b0;
      end
    end
  end

  assign o_vld   = r_vld;
  assign o_dat   = r_dat;
  assign o_beats = r_beats;
  assign o_type  = r_type;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/pipelined_write_rx.sv
// Pipelined-write link receiver: decodes command/data cycles, assembles beats
// into one write and generates wdone/error pulses. Optional bubble timeout
// inside a write is enabled by defining PIPELINED_WRITE_RX_TIMEOUT_EN.
module pipelined_write_rx
  import pipelined_write_rx_pkg::*;
#(
  parameter int MAX_WR_CYCLES  = 4,
  parameter int WR_WIDTH       = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [LINK_W-1:0]                 link_i,
  output logic                              out_vld,
  input  logic                              out_rdy,
  output logic [MAX_WR_CYCLES*WR_WIDTH-1:0] out_dat,
  output logic [2:0]                        out_beats,
  output logic [2:0]                        out_type,
  output logic                              wdone_o,
  output logic                              err_proto_o,
  output logic                              err_ovf_o
);

  localparam int DW = MAX_WR_CYCLES * WR_WIDTH;
  localparam int IW = $clog2(MAX_WR_CYCLES);
  localparam logic [1:0] ST_IDLE  = RX_IDLE;
  localparam logic [1:0] ST_DATA  = RX_DATA;
  localparam logic [1:0] ST_DRAIN = RX_DRAIN;

  write_cmd__st  w_cmd;
  write_dat__st  w_dat;
  logic [1:0]    r_state, w_nxt;
  beat_cnt_t     r_n, r_cnt;
  logic [2:0]    r_type;
  logic [DW-1:0] r_dat, w_asm;
  logic          w_start, w_acc, w_done, w_err, w_bubble, w_last;
  logic          r_wdone, r_err;

  assign w_cmd  = write_cmd__st'(link_i);
  assign w_dat  = write_dat__st'(link_i);
  assign w_last = (r_cnt == beat_cnt_t'(r_n - 3'd1));

`ifdef PIPELINED_WRITE_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_to;
  logic          w_to_hit;
  assign w_to_hit = w_bubble && (r_to == TW'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    w_nxt    = r_state;
    w_start  = 1'b0;
    w_acc    = 1'b0;
    w_done   = 1'b0;
    w_err    = 1'b0;
    w_bubble = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cmd.val) begin
          if (w_cmd.write_type <= WT_SINGLE_WDONE) begin
            w_start = 1'b1;
            w_nxt   = ST_DATA;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      ST_DATA: begin
        case (w_dat.cycle_type)
          CT_IDLE:  w_bubble = 1'b1;
          CT_VALID: if (w_last) w_err = 1'b1; else w_acc = 1'b1;
          CT_DONE: begin
            if (w_last) begin
              w_acc  = 1'b1;
              w_done = 1'b1;
              w_nxt  = ST_IDLE;
            end else begin
              w_err = 1'b1;
            end
          end
          default:  w_err = 1'b1;
        endcase
        if (w_err) w_nxt = ST_DRAIN;
`ifdef PIPELINED_WRITE_RX_TIMEOUT_EN
        if (w_to_hit) begin
          w_err = 1'b1;
          w_nxt = ST_IDLE;
        end
`endif
      end
      ST_DRAIN: begin
        if (w_dat.cycle_type == CT_DONE || w_dat.cycle_type == CT_IDLE) w_nxt = ST_IDLE;
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  // Current beat is merged combinationally so the slot loads the full write on DONE
  always_comb begin
    w_asm = r_dat;
    if (w_acc) w_asm[r_cnt[IW-1:0]*WR_WIDTH +: WR_WIDTH] = w_dat.dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_n     <= '0;
      r_cnt   <= '0;
      r_type  <= '0;
      r_dat   <= '0;
      r_wdone <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_err   <= w_err;
      r_wdone <= w_acc && (r_type == WT_MULTI_WDONE ||
                           (r_type == WT_SINGLE_WDONE && w_done));
      if (w_start) begin
        r_n    <= num_to_beats(w_cmd.num_cycles);
        r_type <= w_cmd.write_type;
        r_cnt  <= '0;
        r_dat  <= '0;
      end else if (w_acc) begin
        r_cnt <= r_cnt + 3'd1;
        r_dat <= w_asm;
      end
    end
  end

`ifdef PIPELINED_WRITE_RX_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst || w_start || w_acc) r_to <= '0;
    else if (w_bubble)           r_to <= r_to + TW'(1);
  end
`endif

  pipelined_write_rx_slot #(.DW(DW)) u_slot (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_done),
    .i_dat   (w_asm),
    .i_beats (r_cnt + 3'd1),
    .i_type  (r_type),
    .i_rdy   (out_rdy),
    .o_vld   (out_vld),
    .o_dat   (out_dat),
    .o_beats (out_beats),
    .o_type  (out_type),
    .o_ovf   (err_ovf_o)
  );

  assign wdone_o     = r_wdone;
  assign err_proto_o = r_err;

endmodule

// File: tb/tb_pipelined_write_rx.sv
// Scoreboard bench for pipelined_write_rx: expected writes queued at stimulus
// time and compared when the output handshakes; pulse outputs checked inline.
module tb_pipelined_write_rx;
  import pipelined_write_rx_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  link_i;
  logic        out_rdy;
  logic        out_vld;
  logic [31:0] out_dat;
  logic [2:0]  out_beats, out_type;
  logic        wdone_o, err_proto_o, err_ovf_o;

  pipelined_write_rx dut (
    .clk(clk), .rst(rst), .link_i(link_i),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat),
    .out_beats(out_beats), .out_type(out_type), .wdone_o(wdone_o),
    .err_proto_o(err_proto_o), .err_ovf_o(err_ovf_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dat;
    logic [2:0]  beats;
    logic [2:0]  typ;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int n_tests = 0, n_fail = 0;
  int n_wdone = 0;
  int w0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && wdone_o) n_wdone++;
    if (!rst && out_vld && out_rdy) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("sb_dat",   out_dat,   e.dat);
        chk("sb_beats", out_beats, e.beats);
        chk("sb_type",  out_type,  e.typ);
      end
    end
  end

  function automatic logic [9:0] cmd(input int num, input int typ);
    return {4'b0101, 1'b1, 2'(num), 3'(typ)};
  endfunction

  function automatic logic [9:0] dv(input int ct, input logic [7:0] d);
    return {2'(ct), d};
  endfunction

  task automatic push(input logic [31:0] d, input int beats, input int typ);
    exp_t x;
    x.dat = d; x.beats = 3'(beats); x.typ = 3'(typ);
    sb.push_back(x);
  endtask

  task automatic cyc(input logic [9:0] l);
    link_i = l;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; link_i = '0; out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", out_vld, 0);
    chk("rst_dat", out_dat, 0);
    chk("rst_beats", out_beats, 0);
    chk("rst_type", out_type, 0);
    chk("rst_pulses", {wdone_o, err_proto_o, err_ovf_o}, 0);
    rst = 1'b0;
    cyc(0);

    // two-beat STD write
    w0 = n_wdone;
    push(32'h0000_3CA5, 2, 0);
    cyc(cmd(2, 0)); cyc(dv(1, 8'hA5)); cyc(dv(2, 8'h3C));
    chk("t1_vld", out_vld, 1);
    cyc(0);
    chk("t1_vld_drop", out_vld, 0);
    chk("t1_wdone", n_wdone - w0, 0);

    // four-beat MULTI_WDONE with bubbles
    w0 = n_wdone;
    cyc(cmd(0, 1));          chk("t2_wd_cmd", wdone_o, 0);
    cyc(dv(1, 8'h11));       chk("t2_wd_b0", wdone_o, 1);
    cyc(0);                  chk("t2_wd_bub", wdone_o, 0);
    cyc(0);
    cyc(dv(1, 8'h22));       chk("t2_wd_b1", wdone_o, 1);
    cyc(dv(1, 8'h33));       chk("t2_wd_b2", wdone_o, 1);
    push(32'h4433_2211, 4, 1);
    cyc(dv(2, 8'h44));       chk("t2_wd_b3", wdone_o, 1);
    chk("t2_beats", out_beats, 4);
    cyc(0);
    chk("t2_wdone_cnt", n_wdone - w0, 4);

    // early DONE is a protocol error, then a normal SINGLE write
    w0 = n_wdone;
    cyc(cmd(3, 2)); cyc(dv(1, 8'h55)); cyc(dv(2, 8'h66));
    chk("t3_err", err_proto_o, 1);
    chk("t3_vld", out_vld, 0);
    cyc(0);
    chk("t3_err_clr", err_proto_o, 0);
    chk("t3_wdone", n_wdone - w0, 0);
    push(32'h77, 1, 2);
    cyc(cmd(1, 2)); cyc(dv(2, 8'h77));
    chk("t3_wd_single", wdone_o, 1);
    chk("t3_vld_next", out_vld, 1);
    cyc(0);

    // overflow: second write dropped while the first is held
    out_rdy = 1'b0;
    push(32'h81, 1, 0);
    cyc(cmd(1, 0)); cyc(dv(2, 8'h81)); cyc(cmd(1, 0)); cyc(dv(2, 8'h82));
    chk("t4_ovf", err_ovf_o, 1);
    chk("t4_hold_dat", out_dat, 32'h81);
    cyc(0);
    chk("t4_ovf_clr", err_ovf_o, 0);
    chk("t4_hold_vld", out_vld, 1);
    out_rdy = 1'b1;
    cyc(0);
    chk("t4_drop", out_vld, 0);

    // completion coincides with handshake of previous write
    out_rdy = 1'b0;
    push(32'h91, 1, 0);
    push(32'h92, 1, 1);
    cyc(cmd(1, 0)); cyc(dv(2, 8'h91)); cyc(cmd(1, 1));
    out_rdy = 1'b1;
    cyc(dv(2, 8'h92));
    chk("t5_vld", out_vld, 1);
    chk("t5_dat", out_dat, 32'h92);
    chk("t5_no_ovf", err_ovf_o, 0);
    cyc(0);
    chk("t5_vld_drop", out_vld, 0);

    // bad write_type stays in IDLE; cycle_type 3 drains
    cyc(cmd(1, 5));
    chk("t6_badtype", err_proto_o, 1);
    push(32'hA1, 1, 0);
    cyc(cmd(1, 0));
    chk("t6_err_clr", err_proto_o, 0);
    cyc(dv(2, 8'hA1));
    chk("t6_vld", out_vld, 1);
    cyc(0);
    cyc(cmd(2, 0)); cyc(dv(3, 8'h00));
    chk("t6_ct3", err_proto_o, 1);
    cyc(dv(1, 8'h05)); cyc(dv(2, 8'h06));
    chk("t6_drain_vld", out_vld, 0);
    push(32'hB1, 1, 0);
    cyc(cmd(1, 0)); cyc(dv(2, 8'hB1));
    chk("t6_after_drain", out_vld, 1);
    cyc(0);

    // long bubble run inside a write
    cyc(cmd(2, 0)); cyc(dv(1, 8'hC1));
`ifdef PIPELINED_WRITE_RX_TIMEOUT_EN
    for (int i = 0; i < 15; i++) cyc(0);
    chk("t7_to_early", err_proto_o, 0);
    cyc(0);
    chk("t7_to_hit", err_proto_o, 1);
    push(32'hD1, 1, 0);
    cyc(cmd(1, 0)); cyc(dv(2, 8'hD1));
    chk("t7_to_recover", out_vld, 1);
`else
    for (int i = 0; i < 20; i++) cyc(0);
    chk("t7_no_to", err_proto_o, 0);
    push(32'hC2C1, 2, 0);
    cyc(dv(2, 8'hC2));
    chk("t7_complete", out_vld, 1);
`endif
    cyc(0);

    // reset mid-write with a held output
    out_rdy = 1'b0;
    cyc(cmd(1, 0)); cyc(dv(2, 8'hE1)); cyc(cmd(2, 0)); cyc(dv(1, 8'hE2));
    rst = 1'b1;
    cyc(0);
    rst = 1'b0;
    chk("t8_vld", out_vld, 0);
    chk("t8_dat", out_dat, 0);
    chk("t8_beats_type", {out_beats, out_type}, 0);
    chk("t8_pulses", {wdone_o, err_proto_o, err_ovf_o}, 0);
    out_rdy = 1'b1;
    push(32'hF1, 1, 0);
    cyc(cmd(1, 0)); cyc(dv(2, 8'hF1));
    chk("t8_after_rst", out_vld, 1);
    cyc(0); cyc(0);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
